// File: rtl/pipe_seq.sv
// rtl/pipe_seq.sv - issue/execute/memory/retire pipeline sequencer with per-stage IDs
module pipe_seq #(
    parameter int ID_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_v,
    output logic            fetch_rdy,
    input  logic [4:0]      i_rs1,
    input  logic [4:0]      i_rs2,
    input  logic            i_use1,
    input  logic            i_use2,
    input  logic            x_load,
    input  logic [4:0]      x_rd,
    input  logic            x_redirect,
    input  logic            m_busy,
    output logic            inst_v_i,
    output logic            inst_v_x,
    output logic            inst_v_m,
    output logic            inst_v_r,
    output logic [ID_W-1:0] ci,
    output logic [ID_W-1:0] cx,
    output logic [ID_W-1:0] cm,
    output logic [ID_W-1:0] cr,
    output logic            inst_kill,
    output logic [ID_W-1:0] ck,
    output logic            stall_i,
    output logic            stall_x
);

    logic            vi;
    logic            vx;
    logic            vm;
    logic            vr;
    logic [ID_W-1:0] next_id;

    logic hold;
    logic haz;
    logic redir;
    logic take;

    // Decode is gated by reset so the handshake stays quiet while state is being cleared.
    always_comb begin
        hold      = 1'b0;
        haz       = 1'b0;
        redir     = 1'b0;
        fetch_rdy = 1'b0;
        stall_i   = 1'b0;
        stall_x   = 1'b0;
        if (!reset) begin
            hold  = vm & m_busy;
            haz   = vi & vx & x_load & (x_rd != 5'd0) &
                    ((i_use1 & (i_rs1 == x_rd)) | (i_use2 & (i_rs2 == x_rd)));
            redir = vx & x_redirect & ~hold;
            fetch_rdy = ~(hold | redir | haz);
            stall_i   = hold | (haz & ~redir);
            stall_x   = hold;
        end
    end

    assign take = fetch_v & fetch_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            vi        <= 1'b0;
            vx        <= 1'b0;
            vm        <= 1'b0;
            vr        <= 1'b0;
            ci        <= '0;
            cx        <= '0;
            cm        <= '0;
            cr        <= '0;
            ck        <= '0;
            next_id   <= '0;
            inst_v_i  <= 1'b0;
            inst_v_x  <= 1'b0;
            inst_v_m  <= 1'b0;
            inst_v_r  <= 1'b0;
            inst_kill <= 1'b0;
        end else begin
            inst_v_i  <= 1'b0;
            inst_v_x  <= 1'b0;
            inst_v_m  <= 1'b0;
            inst_v_r  <= 1'b0;
            inst_kill <= 1'b0;
            if (hold) begin
                vr <= 1'b0;
            end else begin
                vr       <= vm;
                cr       <= cm;
                inst_v_r <= vm;
                vm       <= vx;
                cm       <= cx;
                inst_v_m <= vx;
                if (redir) begin
                    // Only the younger instruction in I is on the wrong path.
                    vx <= 1'b0;
                    vi <= 1'b0;
                    if (vi) begin
                        inst_kill <= 1'b1;
                        ck        <= ci;
                    end
                end else if (haz) begin
                    vx <= 1'b0;
                end else begin
                    vx       <= vi;
                    cx       <= ci;
                    inst_v_x <= vi;
                    vi       <= take;
                    if (take) begin
                        ci       <= next_id;
                        next_id  <= next_id + ID_W'(1);
                        inst_v_i <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_seq.sv
// tb/tb_pipe_seq.sv - directed and randomized checks of pipe_seq against a stage-occupancy model
module tb_pipe_seq;
    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, fetch_v, i_use1, i_use2, x_load, x_redirect, m_busy;
    logic [4:0]   i_rs1, i_rs2, x_rd;
    logic         fetch_rdy, inst_v_i, inst_v_x, inst_v_m, inst_v_r, inst_kill, stall_i, stall_x;
    logic [W-1:0] ci, cx, cm, cr, ck;

    pipe_seq #(.ID_W(W)) dut (
        .clk(clk), .reset(reset), .fetch_v(fetch_v), .fetch_rdy(fetch_rdy),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_use1(i_use1), .i_use2(i_use2),
        .x_load(x_load), .x_rd(x_rd), .x_redirect(x_redirect), .m_busy(m_busy),
        .inst_v_i(inst_v_i), .inst_v_x(inst_v_x), .inst_v_m(inst_v_m), .inst_v_r(inst_v_r),
        .ci(ci), .cx(cx), .cm(cm), .cr(cr), .inst_kill(inst_kill), .ck(ck),
        .stall_i(stall_i), .stall_x(stall_x)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: occupancy/ID per stage (0=I,1=X,2=M,3=R), plus a list of live IDs in program order.
    bit mv[4];
    int mid[4];
    int nid;
    int live[$];
    logic got_rdy, got_si, got_sx;

    task automatic clear_inputs();
        reset = 0; fetch_v = 0; i_use1 = 0; i_use2 = 0; x_load = 0;
        x_redirect = 0; m_busy = 0; i_rs1 = 0; i_rs2 = 0; x_rd = 0;
    endtask

    task automatic step();
        bit hold, haz, redir, er, esi, esx, kill;
        bit [3:0] ent;
        int kid, exp_r;
        hold = 0; haz = 0; redir = 0; er = 0; esi = 0; esx = 0; kill = 0; ent = '0; kid = 0;
        #1;
        if (!reset) begin
            hold  = mv[2] && m_busy;
            haz   = mv[0] && mv[1] && x_load && x_rd != 0 &&
                    ((i_use1 && i_rs1 == x_rd) || (i_use2 && i_rs2 == x_rd));
            redir = mv[1] && x_redirect && !hold;
            er  = !(hold || redir || haz);
            esi = hold || (haz && !redir);
            esx = hold;
        end
        got_rdy = fetch_rdy; got_si = stall_i; got_sx = stall_x;
        check("fetch_rdy", fetch_rdy, er);
        check("stall_i", stall_i, esi);
        check("stall_x", stall_x, esx);

        if (reset) begin
            for (int s = 0; s < 4; s++) begin mv[s] = 0; mid[s] = 0; end
            nid = 0;
            live.delete();
        end else if (hold) begin
            mv[3] = 0;
        end else begin
            mv[3] = mv[2]; mid[3] = mid[2]; ent[3] = mv[2];
            mv[2] = mv[1]; mid[2] = mid[1]; ent[2] = mv[1];
            if (redir) begin
                if (mv[0]) begin
                    kill = 1; kid = mid[0];
                    void'(live.pop_back());
                end
                mv[1] = 0; mv[0] = 0;
            end else if (haz) begin
                mv[1] = 0;
            end else begin
                mv[1] = mv[0]; mid[1] = mid[0]; ent[1] = mv[0];
                mv[0] = 0;
                if (fetch_v) begin
                    mv[0] = 1; mid[0] = nid; ent[0] = 1;
                    live.push_back(nid);
                    nid = (nid + 1) % (1 << W);
                end
            end
        end

        @(posedge clk);
        #1;
        check("inst_v_i", inst_v_i, ent[0]);
        check("inst_v_x", inst_v_x, ent[1]);
        check("inst_v_m", inst_v_m, ent[2]);
        check("inst_v_r", inst_v_r, ent[3]);
        check("inst_kill", inst_kill, kill);
        if (kill) check("ck", ck, kid);
        if (mv[0]) check("ci", ci, mid[0]);
        if (mv[1]) check("cx", cx, mid[1]);
        if (mv[2]) check("cm", cm, mid[2]);
        if (mv[3]) check("cr", cr, mid[3]);
        if (ent[3]) begin
            if (live.size() == 0) check("retire_order_empty", 1, 0);
            else begin
                exp_r = live.pop_front();
                check("retire_order", cr, exp_r);
            end
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    initial begin
        clear_inputs();
        nid = 0;
        for (int s = 0; s < 4; s++) begin mv[s] = 0; mid[s] = 0; end
        do_reset();
        check("rst_ci", ci, 0); check("rst_cx", cx, 0); check("rst_cm", cm, 0);
        check("rst_cr", cr, 0); check("rst_ck", ck, 0);

        // Straight-line: transfers at cycles 0..2, retires at 4..6
        for (int k = 1; k <= 7; k++) begin
            fetch_v = (k <= 3);
            step();
            check("sl_inst_v_i", inst_v_i, (k >= 1 && k <= 3));
            if (k <= 3) check("sl_ci", ci, k - 1);
            check("sl_inst_v_r", inst_v_r, (k >= 4 && k <= 6));
            if (k >= 4 && k <= 6) check("sl_cr", cr, k - 4);
        end

        // Load-use: load id0 in X, dependent id1 in I
        do_reset();
        fetch_v = 1; step(); step();
        fetch_v = 0; x_load = 1; x_rd = 5; i_rs1 = 5; i_use1 = 1;
        step();
        check("lu_stall_i", got_si, 1); check("lu_rdy", got_rdy, 0); check("lu_stall_x", got_sx, 0);
        check("lu_bubble_x", inst_v_x, 0);
        clear_inputs();
        step();
        check("lu_late_x", inst_v_x, 1); check("lu_cx", cx, 1);

        // Same pattern with x_rd = 0: no stall
        do_reset();
        fetch_v = 1; step(); step();
        fetch_v = 0; x_load = 1; x_rd = 0; i_rs1 = 0; i_use1 = 1;
        step();
        check("r0_stall_i", got_si, 0); check("r0_rdy", got_rdy, 1);
        check("r0_x", inst_v_x, 1); check("r0_cx", cx, 1);
        clear_inputs();

        // Memory stall: I=3 X=2 M=1 R=0, then m_busy for two cycles
        do_reset();
        fetch_v = 1;
        for (int k = 0; k < 4; k++) step();
        m_busy = 1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("ms_ci", ci, 3); check("ms_cx", cx, 2); check("ms_cm", cm, 1);
            check("ms_no_pulse", {inst_v_i, inst_v_x, inst_v_m, inst_v_r}, 0);
        end
        m_busy = 0;
        step();
        check("ms_retire", inst_v_r, 1); check("ms_cr", cr, 1); check("ms_ci_next", ci, 4);
        clear_inputs();

        // Redirect: I=8 X=7
        do_reset();
        fetch_v = 1;
        for (int k = 0; k < 9; k++) step();
        x_redirect = 1;
        step();
        check("rd_rdy", got_rdy, 0);
        check("rd_kill", inst_kill, 1); check("rd_ck", ck, 8);
        check("rd_v_m", inst_v_m, 1); check("rd_cm", cm, 7);
        x_redirect = 0;
        step();
        check("rd_next_id", ci, 9); check("rd_next_v", inst_v_i, 1);
        clear_inputs();

        // Hold with redirect: nothing moves until m_busy drops
        do_reset();
        fetch_v = 1;
        for (int k = 0; k < 3; k++) step();
        fetch_v = 0; m_busy = 1; x_redirect = 1;
        step();
        check("hr_no_kill", inst_kill, 0); check("hr_rdy", got_rdy, 0); check("hr_stall_x", got_sx, 1);
        m_busy = 0;
        step();
        check("hr_kill", inst_kill, 1); check("hr_ck", ck, 2); check("hr_cm", cm, 1);
        clear_inputs();

        // Wrap at ID_W=4, then reset mid-flight
        do_reset();
        fetch_v = 1;
        for (int k = 1; k <= 17; k++) begin
            step();
            check("wr_ci", ci, (k - 1) % 16);
        end
        reset = 1;
        step();
        check("wr_rst_kill", inst_kill, 0);
        check("wr_rst_pulses", {inst_v_i, inst_v_x, inst_v_m, inst_v_r}, 0);
        reset = 0;
        step();
        check("wr_after_rst_ci", ci, 0); check("wr_after_rst_v", inst_v_i, 1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            fetch_v    = ($urandom_range(0, 3) != 0);
            i_rs1      = 5'($urandom_range(0, 3));
            i_rs2      = 5'($urandom_range(0, 3));
            i_use1     = $urandom_range(0, 1);
            i_use2     = $urandom_range(0, 1);
            x_load     = $urandom_range(0, 1);
            x_rd       = 5'($urandom_range(0, 3));
            x_redirect = ($urandom_range(0, 6) == 0);
            m_busy     = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/pipe_seq.md
# pipe_seq

Pipeline sequencer for the 4-stage core (I issue, X execute, M memory, R retire). It tracks per-stage occupancy and assigns each fetched instruction a monotonically increasing ID. It resolves load-use stalls, memory back-pressure and X-stage redirects. It drives the per-stage valid pulses and IDs (`inst_v_*`, `c*`) consumed by the commit tracer and the Konata pipeline log.

## Interface
- `ID_W`, default 32: width of instruction IDs and the ID counter; the counter wraps modulo 2^ID_W.
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_v`  in  1  fetch presents an instruction this cycle.
- `fetch_rdy`  out  1  I can accept; transfer when `fetch_v & fetch_rdy`.
- `i_rs1`, `i_rs2`  in  5  source registers of the instruction in I.
- `i_use1`, `i_use2`  in  1  I instruction reads rs1 / rs2.
- `x_load`  in  1  instruction in X is a load.
- `x_rd`  in  5  destination register of the instruction in X.
- `x_redirect`  in  1  X resolved a taken branch/jump this cycle.
- `m_busy`  in  1  M cannot complete this cycle.
- `inst_v_i`, `inst_v_x`, `inst_v_m`, `inst_v_r`  out  1  one-cycle pulse: instruction entered I / X / M / R.
- `ci`, `cx`, `cm`, `cr`  out  ID_W  ID of the instruction occupying I / X / M / R.
- `inst_kill`  out  1  one-cycle pulse: instruction `ck` was squashed.
- `ck`  out  ID_W  ID of the squashed instruction.
- `stall_i`, `stall_x`  out  1  I / X holding its content this cycle (combinational).

## Operation
- State:
  - valid bits `vi`, `vx`, `vm`, `vr`;
  - ID registers per stage;
  - `next_id` counter;
  - entry flags behind the `inst_v_*` outputs.
- Combinational decode each cycle:
  - `hold = vm & m_busy`
  - `haz = vi & vx & x_load & (x_rd != 0) & ((i_use1 & i_rs1 == x_rd) | (i_use2 & i_rs2 == x_rd))`
  - `redir = vx & x_redirect & !hold`
- Priority: `hold` > `redir` > `haz`.
- `hold`:
  - I, X and M keep contents.
  - R receives a bubble (`vr <= 0`).
  - `stall_i = stall_x = 1`.
- `redir` (no hold):
  - X→M and M→R advance.
  - I is squashed (`vi <= 0`); if `vi` was 1, `inst_kill` pulses next cycle with `ck` = old I ID.
  - I does not advance, so X receives a bubble.
  - `haz` is ignored.
- `haz` (no hold, no redir):
  - I holds and X receives a bubble; M and R advance.
  - `stall_i = 1`, `stall_x = 0`.
- Otherwise every stage advances: I→X, X→M, M→R, and R is discarded.
- `fetch_rdy = !(hold | redir | haz)`.
  - On transfer: `vi <= 1`, I ID `<= next_id`, `next_id <= next_id + 1` (mod 2^ID_W).
  - If I empties without a transfer, `vi <= 0`.
- `inst_v_<s>` pulses exactly once per instruction, in the first cycle it occupies stage s; it stays low on held cycles.
- `c<s>` always reflects the stage's ID register. It is don't-care when the stage is invalid, but it is stable while the stage holds.
- Instructions in X, M and R are never squashed.

## Timing
- Reset values: all valid bits, entry flags, `inst_v_*`, `inst_kill` = 0; `next_id`, `ci`, `cx`, `cm`, `cr`, `ck` = 0.
- Combinational outputs while `reset` is high: `fetch_rdy = 0`, `stall_i = stall_x = 0`.
- Latency for a transfer at cycle t with no stalls: `inst_v_i` at t+1, `inst_v_x` at t+2, `inst_v_m` at t+3, `inst_v_r` at t+4, all carrying the same ID.
- Peak throughput is one instruction per cycle.
- Load-use costs exactly one bubble: the dependent instruction enters X two cycles after the load.
- `redir` at cycle t:
  - `fetch_rdy = 0` at t.
  - `inst_kill` at t+1 if I was occupied.
  - The first new instruction can transfer at t+1.
- `m_busy` for n cycles inserts n R bubbles; no ID is lost or duplicated.
- Reset mid-operation: all in-flight instructions are dropped silently, with no `inst_kill`, and `next_id` returns to 0 on the next cycle.
- `next_id` wraps from 2^ID_W−1 to 0 without a stall.

## Test plan
- Straight-line flow: `fetch_v = 1` for 3 cycles from reset.
  - IDs 0, 1, 2 pulse `inst_v_i` at cycles 1, 2, 3.
  - `inst_v_r` pulses at 4, 5, 6 with `cr` = 0, 1, 2.
- Load-use stall: load `x_rd = 5` in X while I has `i_rs1 = 5`, `i_use1 = 1`.
  - `stall_i = 1` and `fetch_rdy = 0` for one cycle, then X receives a bubble.
  - `inst_v_x` for the dependent instruction comes one cycle late.
  - The same case with `x_rd = 0` gives no stall.
- Memory stall: `m_busy` high for 2 cycles with M occupied.
  - `ci`, `cx`, `cm` are frozen and no `inst_v_*` pulses occur for I, X or M.
  - `inst_v_r` is low for 2 cycles, then the M instruction retires.
- Redirect: ID 7 in X, ID 8 in I, `x_redirect` pulsed.
  - Next cycle: `inst_kill = 1`, `ck = 8`, `inst_v_m = 1`, `cm = 7`.
  - The next fetched instruction gets ID 9.
- Simultaneous events:
  - `redir` with `haz`: kill occurs and `haz` is ignored.
  - `hold` with `x_redirect`: nothing moves and no kill occurs until `m_busy` drops.
- Wrap and reset, with `ID_W = 4`:
  - Fetching 17 instructions gives IDs …14, 15, 0.
  - Asserting `reset` mid-flight clears all valid bits with no kill pulse; the next fetch gets ID 0.
